// File: rtl/ioctl_dl_bridge_if.sv
// Bus bundle between hps_io's ioctl download stream and the core memory write port.
// The bridge takes the slave view; hps_io and the memory side together take the master view.
interface ioctl_dl_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int NUM_CH = 2
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [CH_W-1:0]   mem_sel;
  logic              mem_ack;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    output ioctl_wait, mem_req, mem_addr, mem_data, mem_sel
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    input  ioctl_wait, mem_req, mem_addr, mem_data, mem_sel
  );
endinterface

// File: rtl/ioctl_dl_bridge.sv
// Download bridge: filters ioctl_index, skips a header, buffers {addr,data} in a FIFO
// and replays it as req/ack byte writes at a per-channel base address.
module ioctl_dl_bridge #(
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 8,
  parameter int NUM_CH   = 2,
  parameter int IDX_BASE = 0,
  parameter int HDR_SKIP = 0,
  parameter logic [NUM_CH*ADDR_W-1:0] LOAD_BASE = {NUM_CH{16'h0300}}
) (
  input  logic              clk_sys,
  input  logic              reset,
  ioctl_dl_bridge_if.slave  bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   byte_count
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

  state_e            state_q, state_d;
  logic              dl_q, pend_q;
  logic [CH_W-1:0]   ch_q;
  logic [ADDR_W-1:0] base_q, base_sel;

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [7:0]        fifo_data [DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic [CH_W-1:0]   sel_q;
  logic              wait_q, busy_q, done_q, err_q;
  logic [ADDR_W:0]   bcnt_q;

  logic              dl_rise, idx_ok, start;
  logic [7:0]        idx_off;
  logic              wr_acc, full, pop, push, drop;
  logic [ADDR_W-1:0] push_addr;

  assign dl_rise = bus.ioctl_download & ~dl_q;
  assign idx_off = bus.ioctl_index - 8'(IDX_BASE);
  assign idx_ok  = {1'b0, idx_off} < 9'(NUM_CH);
  // pend_q remembers a rising edge that arrived while the previous transfer was still finishing
  assign start   = (state_q == IDLE) && bus.ioctl_download && (dl_rise || pend_q) && idx_ok;

  assign wr_acc    = (state_q == STREAM) && bus.ioctl_wr && (bus.ioctl_addr >= 25'(HDR_SKIP));
  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign pop       = (cnt_q != '0) && !req_q;
  assign push      = wr_acc && (!full || pop);
  assign drop      = wr_acc && full && !pop;
  assign push_addr = base_q + ADDR_W'(bus.ioctl_addr - 25'(HDR_SKIP));

  always_comb begin
    base_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (idx_off == 8'(c)) base_sel = LOAD_BASE[c*ADDR_W +: ADDR_W];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (!bus.ioctl_download) state_d = DRAIN;
      DRAIN:   if ((cnt_q == '0) && !req_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr[wptr_q] <= push_addr;
      fifo_data[wptr_q] <= bus.ioctl_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q   <= 1'b0;
      pend_q <= 1'b0;
      ch_q   <= '0;
      base_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      req_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      sel_q  <= '0;
      wait_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      bcnt_q <= '0;
    end else begin
      dl_q <= bus.ioctl_download;

      if (state_q == IDLE) pend_q <= 1'b0;
      else if (dl_rise)    pend_q <= 1'b1;

      if (start) begin
        ch_q   <= idx_off[CH_W-1:0];
        base_q <= base_sel;
        err_q  <= 1'b0;
        bcnt_q <= '0;
      end else begin
        if (drop) err_q <= 1'b1;
        if (req_q && bus.mem_ack && (bcnt_q != '1)) bcnt_q <= bcnt_q + 1'b1;
      end

      if (push) wptr_q <= wptr_q + 1'b1;

      // a pop only happens with no request outstanding, so the ack and the next load never collide
      if (pop) begin
        addr_q <= fifo_addr[rptr_q];
        data_q <= fifo_data[rptr_q];
        sel_q  <= ch_q;
        rptr_q <= rptr_q + 1'b1;
        req_q  <= 1'b1;
      end else if (req_q && bus.mem_ack) begin
        req_q  <= 1'b0;
      end

      cnt_q  <= cnt_d;
      wait_q <= (cnt_d >= CNT_W'(DEPTH-2)) ||
                (bus.ioctl_download && ((state_d == DRAIN) || (state_d == DONE)));
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.mem_req    = req_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_data   = data_q;
  assign bus.mem_sel    = sel_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign byte_count     = bcnt_q;

endmodule

// File: tb/tb_ioctl_dl_bridge.sv
// Directed bench for ioctl_dl_bridge: ch1 base 0x0300, ch0 base 0xFFFE, 16-byte header skip.
module tb_ioctl_dl_bridge;
  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        busy, done, err;
  logic [16:0] byte_count;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic ack_en = 1'b0;
  logic req_seen = 1'b0, busy_seen = 1'b0;
  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  logic [0:0]  ws[$];

  ioctl_dl_bridge_if #(.ADDR_W(16), .NUM_CH(2)) bus ();

  ioctl_dl_bridge #(
    .ADDR_W(16), .DEPTH(8), .NUM_CH(2), .IDX_BASE(0), .HDR_SKIP(16),
    .LOAD_BASE({16'h0300, 16'hFFFE})
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .bus(bus),
    .busy(busy), .done(done), .err(err), .byte_count(byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  // memory side: ack the cycle after a request is seen, log each accepted write
  always @(negedge clk_sys) begin
    if (bus.mem_ack) bus.mem_ack = 1'b0;
    else if (bus.mem_req && ack_en) begin
      bus.mem_ack = 1'b1;
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_data);
      ws.push_back(bus.mem_sel);
    end
    if (done) done_cnt++;
    if (bus.mem_req) req_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); ws.delete();
    done_cnt = 0; req_seen = 1'b0; busy_seen = 1'b0;
  endtask

  task automatic dl_start(input logic [7:0] idx);
    @(negedge clk_sys);
    bus.ioctl_index = idx;
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic dl_end();
    @(negedge clk_sys);
    bus.ioctl_download = 1'b0;
  endtask

  task automatic burst(input int off0, input int d0, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b1;
      bus.ioctl_addr = 25'(off0 + i);
      bus.ioctl_dout = 8'(d0 + i);
      if (gap > 0) begin
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        repeat (gap - 1) @(negedge clk_sys);
      end
    end
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    repeat (3) @(negedge clk_sys);
    chk(tag, done_cnt, 1);
  endtask

  task automatic chk_writes(input string tag, input int n, input logic [15:0] a0,
                            input logic [7:0] d0, input logic s);
    chk({tag, "_nwr"}, wa.size(), n);
    if (wa.size() == n)
      for (int i = 0; i < n; i++) begin
        chk({tag, "_addr"}, wa[i], 32'(16'(a0 + 16'(i))));
        chk({tag, "_data"}, wd[i], 32'(8'(d0 + 8'(i))));
        chk({tag, "_sel"},  ws[i], 32'(s));
      end
  endtask

  task automatic basic_load(input string tag);
    clr();
    ack_en = 1'b1;
    dl_start(8'd1);
    burst(0, 8'h00, 20, 3);
    dl_end();
    wait_done({tag, "_done"});
    chk_writes(tag, 4, 16'h0300, 8'h10, 1'b1);
    chk({tag, "_bcnt"}, byte_count, 4);
    chk({tag, "_err"},  err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = 8'd0;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    bus.mem_ack = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err",  err, 0);
    chk("rst_bcnt", byte_count, 0);
    chk("rst_req",  bus.mem_req, 0);
    chk("rst_wait", bus.ioctl_wait, 0);
    reset = 1'b0;

    basic_load("basic");

    // backpressure: strobe only while wait is low, no acks
    clr();
    ack_en = 1'b0;
    dl_start(8'd1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_sys);
      if (bus.ioctl_wait) begin
        bus.ioctl_wr = 1'b0;
        break;
      end
      bus.ioctl_wr = 1'b1;
      bus.ioctl_addr = 25'(16 + n);
      bus.ioctl_dout = 8'(8'h40 + n);
      n++;
    end
    bus.ioctl_wr = 1'b0;
    chk("bp_nstrobe", n, 7);
    chk("bp_wait", bus.ioctl_wait, 1);
    repeat (4) @(negedge clk_sys);
    chk("bp_err", err, 0);
    chk("bp_req_held", bus.mem_req, 1);
    ack_en = 1'b1;
    dl_end();
    wait_done("bp_done");
    chk_writes("bp", 7, 16'h0300, 8'h40, 1'b1);
    chk("bp_bcnt", byte_count, 7);

    // overflow: 12 back-to-back strobes ignoring wait
    clr();
    ack_en = 1'b0;
    dl_start(8'd1);
    chk("ovf_err_clr", err, 0);
    burst(16, 8'h80, 12, 0);
    chk("ovf_err", err, 1);
    ack_en = 1'b1;
    dl_end();
    wait_done("ovf_done");
    chk_writes("ovf", 9, 16'h0300, 8'h80, 1'b1);
    chk("ovf_bcnt", byte_count, 9);
    chk("ovf_err_sticky", err, 1);

    // index filter: index 5 is outside 0..1
    clr();
    dl_start(8'd5);
    burst(0, 8'h20, 10, 0);
    dl_end();
    repeat (10) @(negedge clk_sys);
    chk("flt_req", req_seen, 0);
    chk("flt_busy", busy_seen, 0);
    chk("flt_done", done_cnt, 0);
    chk("flt_err_hold", err, 1);
    chk("flt_bcnt_hold", byte_count, 9);

    // address wrap on channel 0 (base 0xFFFE)
    clr();
    dl_start(8'd0);
    chk("wrap_err_clr", err, 0);
    chk("wrap_bcnt_clr", byte_count, 0);
    burst(16, 8'hA0, 4, 0);
    dl_end();
    wait_done("wrap_done");
    chk_writes("wrap", 4, 16'hFFFE, 8'hA0, 1'b0);

    // reset while draining
    clr();
    ack_en = 1'b0;
    dl_start(8'd1);
    burst(16, 8'h60, 4, 0);
    dl_end();
    repeat (3) @(negedge clk_sys);
    chk("rd_busy_pre", busy, 1);
    chk("rd_req_pre", bus.mem_req, 1);
    reset = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("rd_req", bus.mem_req, 0);
    chk("rd_busy", busy, 0);
    @(negedge clk_sys);
    reset = 1'b0;
    ack_en = 1'b1;
    repeat (10) @(negedge clk_sys);
    chk("rd_nodone", done_cnt, 0);
    chk("rd_nowr", wa.size(), 0);

    basic_load("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
